// File: rtl/conv_tile_loader_pkg.sv
// Shared convolution constants: operand geometry, loader FSM encoding and
// the byte-index convention (i = r*edge + c) used to pack tiles and filters.
package conv_tile_loader_pkg;

    localparam int PIX_W = 8;
    localparam int TILE  = 4;
    localparam int K     = 3;
    localparam int NPIX  = TILE * TILE;
    localparam int NWGT  = K * K;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILT = 2'd1,
        PIX  = 2'd2,
        HOLD = 2'd3
    } state_e;

    // Element (r, c) of a square operand with the given edge length.
    function automatic int byte_idx(input int r, input int c, input int edgeLen);
        return r * edgeLen + c;
    endfunction

    // Lowest bit of packed element idx.
    function automatic int byte_lsb(input int idx);
        return idx * PIX_W;
    endfunction

endpackage

// File: rtl/conv_tile_loader.sv
// Byte-serial loader: stages 9 filter weights and writes 16 pixels, then
// presents DATA/FILTER to the convolution engine with a valid/ready handshake.
module conv_tile_loader
    import conv_tile_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PIX_W-1:0]        in_data,
    input  logic                    in_filt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NPIX*PIX_W-1:0]   DATA,
    output logic [NWGT*PIX_W-1:0]   FILTER,
    output logic [1:0]              state,
    output logic                    err,
    output logic [7:0]              err_cnt
);

    state_e                  state_q, state_d;
    logic [3:0]              fcnt_q, fcnt_d;
    logic [3:0]              pcnt_q, pcnt_d;
    logic [NWGT*PIX_W-1:0]   stage_q, stage_d;
    logic [NWGT*PIX_W-1:0]   filter_q, filter_d;
    logic [NPIX*PIX_W-1:0]   data_q, data_d;
    logic                    filt_ok_q, filt_ok_d;
    logic                    err_q, err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic                    accept;
    logic                    proto_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            fcnt_q    <= '0;
            pcnt_q    <= '0;
            stage_q   <= '0;
            filter_q  <= '0;
            data_q    <= '0;
            filt_ok_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            fcnt_q    <= fcnt_d;
            pcnt_q    <= pcnt_d;
            stage_q   <= stage_d;
            filter_q  <= filter_d;
            data_q    <= data_d;
            filt_ok_q <= filt_ok_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        fcnt_d    = fcnt_q;
        pcnt_d    = pcnt_q;
        stage_d   = stage_q;
        filter_d  = filter_q;
        data_d    = data_q;
        filt_ok_d = filt_ok_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        proto_err = 1'b0;
        accept    = in_valid && (state_q != HOLD);

        case (state_q)
            IDLE: if (accept) begin
                if (in_filt) begin
                    stage_d[byte_lsb(0) +: PIX_W] = in_data;
                    fcnt_d  = 4'd1;
                    state_d = FILT;
                end else if (filt_ok_q) begin
                    data_d[byte_lsb(0) +: PIX_W] = in_data;
                    pcnt_d  = 4'd1;
                    state_d = PIX;
                end else begin
                    proto_err = 1'b1;
                end
            end
            FILT: if (accept) begin
                if (in_filt) begin
                    for (int j = 1; j < NWGT; j++)
                        if (fcnt_q == 4'(j)) stage_d[byte_lsb(j) +: PIX_W] = in_data;
                    // The 9th weight lands in the same cycle it is committed.
                    if (fcnt_q == 4'(NWGT - 1)) begin
                        filter_d  = stage_d;
                        filt_ok_d = 1'b1;
                        fcnt_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        fcnt_d = fcnt_q + 4'd1;
                    end
                end else begin
                    proto_err = 1'b1;
                end
            end
            PIX: if (accept) begin
                if (!in_filt) begin
                    for (int i = 1; i < NPIX; i++)
                        if (pcnt_q == 4'(i)) data_d[byte_lsb(i) +: PIX_W] = in_data;
                    if (pcnt_q == 4'(NPIX - 1)) begin
                        pcnt_d  = '0;
                        state_d = HOLD;
                    end else begin
                        pcnt_d = pcnt_q + 4'd1;
                    end
                end else begin
                    proto_err = 1'b1;
                end
            end
            HOLD: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Offending byte is dropped; any partial frame is abandoned.
        if (proto_err) begin
            state_d = IDLE;
            fcnt_d  = '0;
            pcnt_d  = '0;
            err_d   = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign DATA      = data_q;
    assign FILTER    = filter_q;
    assign state     = state_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_conv_tile_loader.sv
// Randomized and directed bench for conv_tile_loader, checked every cycle
// against a frame-level queue model of the loader.
module tb_conv_tile_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_filt = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] DATA;
    logic [71:0]  FILTER;
    logic [1:0]   state;
    logic         err;
    logic [7:0]   err_cnt;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 0;
    bit randGaps = 0;
    bit randOut = 0;

    conv_tile_loader dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_filt(in_filt),
        .out_valid(out_valid), .out_ready(out_ready),
        .DATA(DATA), .FILTER(FILTER), .state(state),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Frame-level model: bytes collected in queues, committed operands in arrays.
    logic [7:0] wq[$];
    logic [7:0] pq[$];
    logic [7:0] filtM[9];
    logic [7:0] tileM[16];
    bit presenting, filtOk, errM, dataClean;
    int errCnt;

    always @(posedge clk) begin
        if (rst) begin
            wq.delete(); pq.delete();
            for (int j = 0; j < 9; j++) filtM[j] = 8'h00;
            for (int i = 0; i < 16; i++) tileM[i] = 8'h00;
            presenting = 0; filtOk = 0; errM = 0; errCnt = 0; dataClean = 1;
        end else begin
            bit bad;
            bad = 0;
            errM = 0;
            if (presenting) begin
                if (out_ready) presenting = 0;
            end else if (in_valid) begin
                if (in_filt) begin
                    if (pq.size() != 0) begin
                        pq.delete(); bad = 1;
                    end else begin
                        wq.push_back(in_data);
                        if (wq.size() == 9) begin
                            for (int j = 0; j < 9; j++) filtM[j] = wq[j];
                            filtOk = 1;
                            wq.delete();
                        end
                    end
                end else begin
                    if (wq.size() != 0) begin
                        wq.delete(); bad = 1;
                    end else if (!filtOk) begin
                        bad = 1;
                    end else begin
                        dataClean = 0;
                        pq.push_back(in_data);
                        if (pq.size() == 16) begin
                            for (int i = 0; i < 16; i++) tileM[i] = pq[i];
                            presenting = 1;
                            pq.delete();
                        end
                    end
                end
            end
            if (bad) begin
                errM = 1;
                if (errCnt < 255) errCnt++;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [71:0]  expF;
            logic [127:0] expD;
            logic [1:0]   expS;
            for (int j = 0; j < 9; j++) expF[j*8 +: 8] = filtM[j];
            for (int i = 0; i < 16; i++) expD[i*8 +: 8] = dataClean ? 8'h00 : tileM[i];
            expS = presenting ? 2'd3 : (pq.size() != 0) ? 2'd2 : (wq.size() != 0) ? 2'd1 : 2'd0;
            checkOutput("in_ready", 128'(in_ready), 128'(!presenting));
            checkOutput("out_valid", 128'(out_valid), 128'(presenting));
            checkOutput("state", 128'(state), 128'(expS));
            checkOutput("err", 128'(err), 128'(errM));
            checkOutput("err_cnt", 128'(err_cnt), 128'(errCnt));
            checkOutput("FILTER", 128'(FILTER), 128'(expF));
            if (presenting || dataClean) checkOutput("DATA", DATA, expD);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (randOut) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input bit filt, input logic [7:0] data);
        bit rdy;
        int budget;
        if (randGaps) repeat ($urandom_range(0, 2)) tick();
        in_valid = 1'b1;
        in_filt  = filt;
        in_data  = data;
        budget = 0;
        do begin
            rdy = in_ready;
            tick();
            budget++;
        end while (!rdy && budget < 200);
        checkOutput("acceptWait", 128'(rdy), 128'(1));
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_filt  = 1'($urandom);
    endtask

    task automatic sendWeights(input logic [7:0] first);
        for (int j = 0; j < 9; j++) applyStimulus(1'b1, first + 8'(j));
    endtask

    task automatic sendPixels(input logic [7:0] first);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, first + 8'(i));
    endtask

    localparam logic [71:0]  FILT1 = 72'h090807060504030201;
    localparam logic [127:0] TILE1 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] TILE2 = 128'h2F2E2D2C2B2A29282726252423222120;
    localparam logic [127:0] TILE3 = 128'h3F3E3D3C3B3A39383736353433323130;

    initial begin
        tick();
        doReset();
        checkEn = 1;
        checkOutput("rstDATA", DATA, 128'h0);
        checkOutput("rstInReady", 128'(in_ready), 128'(1));

        // Basic tile
        out_ready = 1'b1;
        sendWeights(8'h01);
        checkOutput("basicFILTER", 128'(FILTER), 128'(FILT1));
        sendPixels(8'h10);
        checkOutput("basicValid", 128'(out_valid), 128'(1));
        checkOutput("basicDATA", DATA, TILE1);
        tick();
        checkOutput("basicValidDrop", 128'(out_valid), 128'(0));

        // Pixel before any filter
        doReset();
        applyStimulus(1'b0, 8'h55);
        checkOutput("noFiltErr", 128'(err), 128'(1));
        checkOutput("noFiltCnt", 128'(err_cnt), 128'(1));
        checkOutput("noFiltState", 128'(state), 128'(0));
        tick();
        checkOutput("noFiltErrDrop", 128'(err), 128'(0));

        // Backpressure and filter reuse
        sendWeights(8'h01);
        out_ready = 1'b0;
        sendPixels(8'h10);
        repeat (10) tick();
        checkOutput("bpInReady", 128'(in_ready), 128'(0));
        checkOutput("bpDATA", DATA, TILE1);
        out_ready = 1'b1;
        tick();
        sendPixels(8'h20);
        checkOutput("reuseDATA", DATA, TILE2);
        checkOutput("reuseFILTER", 128'(FILTER), 128'(FILT1));
        tick();

        // Weight inside a pixel run
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h40 + 8'(i));
        applyStimulus(1'b1, 8'hEE);
        checkOutput("wInPixErr", 128'(err), 128'(1));
        sendPixels(8'h30);
        checkOutput("wInPixDATA", DATA, TILE3);
        tick();

        // Pixel inside a weight run
        for (int j = 0; j < 4; j++) applyStimulus(1'b1, 8'hA0 + 8'(j));
        applyStimulus(1'b0, 8'h66);
        checkOutput("pInWErr", 128'(err), 128'(1));
        checkOutput("pInWFILTER", 128'(FILTER), 128'(FILT1));
        sendPixels(8'h10);
        checkOutput("pInWFiltOk", 128'(out_valid), 128'(1));

        // Reset in HOLD
        out_ready = 1'b0;
        tick();
        doReset();
        checkOutput("rstHoldValid", 128'(out_valid), 128'(0));
        checkOutput("rstHoldDATA", DATA, 128'h0);
        checkOutput("rstHoldFILTER", 128'(FILTER), 128'h0);
        checkOutput("rstHoldCnt", 128'(err_cnt), 128'(0));
        out_ready = 1'b1;
        applyStimulus(1'b0, 8'h77);
        checkOutput("rstHoldErr", 128'(err), 128'(1));

        // Error counter saturation
        repeat (260) applyStimulus(1'b0, 8'h55);
        checkOutput("errSat", 128'(err_cnt), 128'(255));

        // Randomized frames with gaps, backpressure and injected protocol errors
        doReset();
        randGaps = 1;
        randOut = 1;
        for (int f = 0; f < 60; f++) begin
            bit isW;
            int len, badPos;
            isW = ($urandom_range(0, 3) == 0);
            len = isW ? 9 : 16;
            badPos = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            for (int b = 0; b < len; b++)
                applyStimulus((b == badPos) ? !isW : isW, 8'($urandom));
        end
        randOut = 0;
        randGaps = 0;
        out_ready = 1'b1;
        repeat (4) tick();

        checkEn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
